filt_yval_multi: RTL and testbench

- Parametrised successor to the single-word Y-row filter; sits between the change.txt reader, yMem and calc_y.
- For each change record (row i, col j, ΔY), scans the packed sparse rows of Y in yMem. Rows may span several memory words.
- Returns Yii and Yij for pass 1 (row i), then Yjj and Yji for pass 2 (row j), each with ΔY.
- Holds calc_y off with a valid/ready handshake until each pass's result is consumed.

---
 rtl/filt_yval_multi_if.sv | 55 +++++
 rtl/filt_yval_multi.sv | 234 +++++++++++++++++++++++
 tb/tb_filt_yval_multi.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/filt_yval_multi_if.sv
// Bus bundle between the change reader, yMem and calc_y for filt_yval_multi.
// op_err exists only when FILT_YVAL_TIMEOUT_EN is defined.
interface filt_yval_multi_if #(
  parameter int IDX_W   = 16,
  parameter int VAL_W   = 48,
  parameter int ENTRIES = 4,
  parameter int ADDR_W  = 16
) ();
  // Result handshake: op_EX_EN is valid, ex_ready is ready. A result moves on
  // every rising clock edge where both are high. Once op_EX_EN is raised, it
  // and all result fields stay constant until that transfer. ex_ready may be
  // high before op_EX_EN rises.
  logic                             filt_EN;
  logic [IDX_W-1:0]                 chng_row;
  logic [IDX_W-1:0]                 chng_col;
  logic [VAL_W/2-1:0]               chng_real;
  logic [VAL_W/2-1:0]               chng_img;
  logic                             op_rd_en;
  logic [ADDR_W-1:0]                op_rd_addr;
  logic                             dataReady;
  logic [ENTRIES*(IDX_W+VAL_W)-1:0] ymem_data;
  logic                             op_EX_EN;
  logic                             ex_ready;
  logic                             op_pass;
  logic [VAL_W-1:0]                 op_yVal1;
  logic [VAL_W-1:0]                 op_yVal2;
  logic [VAL_W-1:0]                 op_dVal;
  logic                             op_diag_hit;
  logic                             op_off_hit;
  logic                             op_busy;
  logic                             op_Done;
`ifdef FILT_YVAL_TIMEOUT_EN
  logic                             op_err;
`endif

  modport master (
    output filt_EN, chng_row, chng_col, chng_real, chng_img,
    output dataReady, ymem_data, ex_ready,
    input  op_rd_en, op_rd_addr, op_EX_EN, op_pass, op_yVal1, op_yVal2,
    input  op_dVal, op_diag_hit, op_off_hit, op_busy, op_Done
`ifdef FILT_YVAL_TIMEOUT_EN
    , input op_err
`endif
  );

  modport slave (
    input  filt_EN, chng_row, chng_col, chng_real, chng_img,
    input  dataReady, ymem_data, ex_ready,
    output op_rd_en, op_rd_addr, op_EX_EN, op_pass, op_yVal1, op_yVal2,
    output op_dVal, op_diag_hit, op_off_hit, op_busy, op_Done
`ifdef FILT_YVAL_TIMEOUT_EN
    , output op_err
`endif
  );
endinterface

// File: rtl/filt_yval_multi.sv
// Multi-word Y-row filter: fetches Yii/Yij then Yjj/Yji for each change record.
// Optional WAIT timeout with op_err is enabled by defining FILT_YVAL_TIMEOUT_EN.
module filt_yval_multi #(
  parameter int IDX_W         = 16,
  parameter int VAL_W         = 48,
  parameter int ENTRIES       = 4,
  parameter int WORDS_PER_ROW = 2,
  parameter int ADDR_W        = 16
) (
  input  logic               clock,
  input  logic               reset,
  filt_yval_multi_if.slave   bus,
  output logic [2:0]         o_dbg_state
);

  localparam int EW      = IDX_W + VAL_W;
  localparam int WORD_W  = ENTRIES * EW;
  localparam int WIDX_W  = (WORDS_PER_ROW > 1) ? $clog2(WORDS_PER_ROW) : 1;
  localparam int AFULL_W = IDX_W + ADDR_W + WIDX_W;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_WAIT = 3'd2,
    S_SCAN = 3'd3,
    S_EMIT = 3'd4,
    S_DONE = 3'd5
  } state_t;

  state_t              r_state;
  logic [IDX_W-1:0]    r_row_i;
  logic [IDX_W-1:0]    r_col_j;
  logic [VAL_W-1:0]    r_dval;
  logic [IDX_W-1:0]    r_cur_row;
  logic [IDX_W-1:0]    r_cur_col;
  logic [WIDX_W-1:0]   r_widx;
  logic                r_pass;
  logic                r_diag_found;
  logic                r_off_found;
  logic [VAL_W-1:0]    r_yval1;
  logic [VAL_W-1:0]    r_yval2;
  logic [WORD_W-1:0]   r_word;
  logic                r_rd_en;
  logic [ADDR_W-1:0]   r_rd_addr;
  logic                r_ex_en;
  logic                r_done;
  logic                r_busy;
`ifdef FILT_YVAL_TIMEOUT_EN
  logic [11:0]         r_to_cnt;
  logic                r_err;
`endif

  logic                w_diag_hit;
  logic                w_off_hit;
  logic [VAL_W-1:0]    w_yval1;
  logic [VAL_W-1:0]    w_yval2;
  logic                w_end_seen;
  logic                w_pass_done;

  function automatic logic [ADDR_W-1:0] row_addr(input logic [IDX_W-1:0]  row,
                                                 input logic [WIDX_W-1:0] widx);
    logic [AFULL_W-1:0] full;
    full = AFULL_W'(row) * AFULL_W'(WORDS_PER_ROW) + AFULL_W'(widx);
    return full[ADDR_W-1:0];
  endfunction

  // Match flags carry across words of the same pass so an earlier hit wins.
  always_comb begin : scan_word
    logic [IDX_W-1:0] idx;
    logic [VAL_W-1:0] val;
    w_diag_hit = r_diag_found;
    w_off_hit  = r_off_found;
    w_yval1    = r_yval1;
    w_yval2    = r_yval2;
    w_end_seen = 1'b0;
    idx        = '0;
    val        = '0;
    for (int k = 0; k < ENTRIES; k++) begin
      idx = r_word[(ENTRIES-1-k)*EW + VAL_W +: IDX_W];
      val = r_word[(ENTRIES-1-k)*EW +: VAL_W];
      if (!w_end_seen) begin
        if (idx == {IDX_W{1'b1}}) begin
          w_end_seen = 1'b1;
        end else begin
          if (!w_diag_hit && idx == r_cur_row) begin
            w_diag_hit = 1'b1;
            w_yval1    = val;
          end
          if (!w_off_hit && idx == r_cur_col) begin
            w_off_hit = 1'b1;
            w_yval2   = val;
          end
        end
      end
    end
  end

  assign w_pass_done = (w_diag_hit && w_off_hit) || w_end_seen ||
                       (r_widx == WIDX_W'(WORDS_PER_ROW - 1));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_row_i      <= '0;
      r_col_j      <= '0;
      r_dval       <= '0;
      r_cur_row    <= '0;
      r_cur_col    <= '0;
      r_widx       <= '0;
      r_pass       <= 1'b0;
      r_diag_found <= 1'b0;
      r_off_found  <= 1'b0;
      r_yval1      <= '0;
      r_yval2      <= '0;
      r_word       <= '0;
      r_rd_en      <= 1'b0;
      r_rd_addr    <= '0;
      r_ex_en      <= 1'b0;
      r_done       <= 1'b0;
      r_busy       <= 1'b0;
`ifdef FILT_YVAL_TIMEOUT_EN
      r_to_cnt     <= '0;
      r_err        <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.filt_EN) begin
            r_row_i      <= bus.chng_row;
            r_col_j      <= bus.chng_col;
            r_dval       <= {bus.chng_real, bus.chng_img};
            r_cur_row    <= bus.chng_row;
            r_cur_col    <= bus.chng_col;
            r_widx       <= '0;
            r_pass       <= 1'b0;
            r_diag_found <= 1'b0;
            r_off_found  <= 1'b0;
            r_yval1      <= '0;
            r_yval2      <= '0;
            r_rd_en      <= 1'b1;
            r_rd_addr    <= row_addr(bus.chng_row, '0);
            r_busy       <= 1'b1;
            r_state      <= S_REQ;
          end
        end
        S_REQ: begin
          r_rd_en  <= 1'b0;
`ifdef FILT_YVAL_TIMEOUT_EN
          r_to_cnt <= '0;
`endif
          r_state  <= S_WAIT;
        end
        S_WAIT: begin
          if (bus.dataReady) begin
            r_word  <= bus.ymem_data;
            r_state <= S_SCAN;
          end
`ifdef FILT_YVAL_TIMEOUT_EN
          else if (r_to_cnt == 12'hFFF) begin
            r_done  <= 1'b1;
            r_err   <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_to_cnt <= r_to_cnt + 12'd1;
          end
`endif
        end
        S_SCAN: begin
          r_diag_found <= w_diag_hit;
          r_off_found  <= w_off_hit;
          r_yval1      <= w_yval1;
          r_yval2      <= w_yval2;
          if (w_pass_done) begin
            r_ex_en <= 1'b1;
            r_state <= S_EMIT;
          end else begin
            r_widx    <= r_widx + WIDX_W'(1);
            r_rd_en   <= 1'b1;
            r_rd_addr <= row_addr(r_cur_row, r_widx + WIDX_W'(1));
            r_state   <= S_REQ;
          end
        end
        S_EMIT: begin
          if (bus.ex_ready) begin
            r_ex_en <= 1'b0;
            // Row-j pass swaps roles so yVal1 stays the diagonal term.
            if (!r_pass && (r_row_i != r_col_j)) begin
              r_cur_row    <= r_col_j;
              r_cur_col    <= r_row_i;
              r_pass       <= 1'b1;
              r_widx       <= '0;
              r_diag_found <= 1'b0;
              r_off_found  <= 1'b0;
              r_yval1      <= '0;
              r_yval2      <= '0;
              r_rd_en      <= 1'b1;
              r_rd_addr    <= row_addr(r_col_j, '0);
              r_state      <= S_REQ;
            end else begin
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
`ifdef FILT_YVAL_TIMEOUT_EN
          r_err   <= 1'b0;
`endif
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.op_rd_en    = r_rd_en;
  assign bus.op_rd_addr  = r_rd_addr;
  assign bus.op_EX_EN    = r_ex_en;
  assign bus.op_pass     = r_pass;
  assign bus.op_yVal1    = r_yval1;
  assign bus.op_yVal2    = r_yval2;
  assign bus.op_dVal     = r_dval;
  assign bus.op_diag_hit = r_diag_found;
  assign bus.op_off_hit  = r_off_found;
  assign bus.op_busy     = r_busy;
  assign bus.op_Done     = r_done;
`ifdef FILT_YVAL_TIMEOUT_EN
  assign bus.op_err      = r_err;
`endif
  assign o_dbg_state     = r_state;

endmodule

// File: tb/tb_filt_yval_multi.sv
// Randomized and directed bench for filt_yval_multi with a yMem responder and
// a row-scan reference model feeding an expected-result queue.
module tb_filt_yval_multi;

  localparam int IDX_W   = 16;
  localparam int VAL_W   = 48;
  localparam int ENTRIES = 4;
  localparam int WPR     = 2;
  localparam int ADDR_W  = 16;
  localparam int EW      = IDX_W + VAL_W;
  localparam int WORD_W  = ENTRIES * EW;
  localparam int RES_W   = 3 + 3 * VAL_W;
  localparam int CHK_W   = 192;
  localparam logic [EW-1:0] END_E = {{IDX_W{1'b1}}, {VAL_W{1'b0}}};

  // ---------------- clock / reset ----------------
  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [2:0] dbg_state;
  always #5 clock = ~clock;

  filt_yval_multi_if #(.IDX_W(IDX_W), .VAL_W(VAL_W), .ENTRIES(ENTRIES), .ADDR_W(ADDR_W)) bus ();

  filt_yval_multi #(
    .IDX_W(IDX_W), .VAL_W(VAL_W), .ENTRIES(ENTRIES), .WORDS_PER_ROW(WPR), .ADDR_W(ADDR_W)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [RES_W-1:0]  exp_q[$];
  int                addr_q[$];
  logic [WORD_W-1:0] mem[int];
  int rd_cnt = 0, done_cnt = 0, cyc = 0, last_xfer_cyc = 0;
  bit hold_rdy = 1'b0, rdy_rand = 1'b0;
  int force_delay = -1;

  task automatic check(input string tag, input logic [CHK_W-1:0] got, input logic [CHK_W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [EW-1:0] ent(input int idx, input logic [VAL_W-1:0] v);
    return {idx[IDX_W-1:0], v};
  endfunction

  function automatic logic [WORD_W-1:0] mem_rd(input int a);
    if (mem.exists(a)) return mem[a];
    return {ENTRIES{END_E}};
  endfunction

  function automatic logic [VAL_W-1:0] rand_val();
    logic [63:0] t;
    t = {$urandom(), $urandom()};
    return t[VAL_W-1:0];
  endfunction

  function automatic logic [CHK_W-1:0] outs();
    return CHK_W'({bus.op_rd_en, bus.op_rd_addr, bus.op_EX_EN, bus.op_pass, bus.op_yVal1,
                   bus.op_yVal2, bus.op_dVal, bus.op_diag_hit, bus.op_off_hit,
                   bus.op_busy, bus.op_Done});
  endfunction

  // Reference: walk row r word by word, first match per column wins, end marker stops.
  task automatic model_pass(input int r, input int c, input bit p,
                            input logic [VAL_W-1:0] dv, inout int n_rd);
    bit dh, oh, stop;
    logic [VAL_W-1:0] y1, y2;
    logic [WORD_W-1:0] word;
    logic [EW-1:0] e;
    int idx;
    dh = 0; oh = 0; stop = 0; y1 = '0; y2 = '0;
    for (int w = 0; w < WPR && !stop; w++) begin
      addr_q.push_back(r * WPR + w);
      n_rd++;
      word = mem_rd(r * WPR + w);
      for (int k = 0; k < ENTRIES && !stop; k++) begin
        e   = word[(ENTRIES-1-k)*EW +: EW];
        idx = int'(e[EW-1 -: IDX_W]);
        if (idx == (1 << IDX_W) - 1) stop = 1;
        else begin
          if (!dh && idx == r) begin dh = 1; y1 = e[VAL_W-1:0]; end
          if (!oh && idx == c) begin oh = 1; y2 = e[VAL_W-1:0]; end
        end
      end
      if (dh && oh) stop = 1;
    end
    exp_q.push_back({p, dh, oh, y1, y2, dv});
  endtask

  // ---------------- yMem responder ----------------
  initial begin
    bus.dataReady = 1'b0;
    bus.ymem_data = '0;
    forever begin
      @(negedge clock);
      if (reset && bus.op_rd_en) begin
        int a, d;
        a = int'(bus.op_rd_addr);
        d = (force_delay >= 0) ? force_delay : int'($urandom_range(0, 3));
        @(negedge clock);
        repeat (d) @(negedge clock);
        bus.dataReady = 1'b1;
        bus.ymem_data = mem_rd(a);
        @(negedge clock);
        bus.dataReady = 1'b0;
      end
    end
  end

  // ---------------- monitor / ex_ready driver ----------------
  initial begin
    logic [RES_W-1:0] e;
    bus.ex_ready = 1'b0;
    forever begin
      @(negedge clock);
      cyc++;
      if (reset) begin
        if (bus.op_rd_en) begin
          rd_cnt++;
          if (addr_q.size() > 0) check("rd_addr", CHK_W'(bus.op_rd_addr), CHK_W'(addr_q.pop_front()));
          else check("rd_extra", CHK_W'(bus.op_rd_en), '0);
        end
        bus.ex_ready = hold_rdy ? 1'b0 : (rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1);
        if (bus.op_EX_EN && bus.ex_ready) begin
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("ex_pass_hits", CHK_W'({bus.op_pass, bus.op_diag_hit, bus.op_off_hit}), CHK_W'(e[RES_W-1 -: 3]));
            check("ex_yval1", CHK_W'(bus.op_yVal1), CHK_W'(e[3*VAL_W-1 -: VAL_W]));
            check("ex_yval2", CHK_W'(bus.op_yVal2), CHK_W'(e[2*VAL_W-1 -: VAL_W]));
            check("ex_dval", CHK_W'(bus.op_dVal), CHK_W'(e[VAL_W-1:0]));
          end else begin
            check("ex_extra", CHK_W'(bus.op_EX_EN), '0);
          end
          last_xfer_cyc = cyc;
        end
        if (bus.op_Done) begin
          done_cnt++;
          check("done_gap", CHK_W'(cyc - last_xfer_cyc), CHK_W'(1));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic start_record(input int i, input int j, input logic [VAL_W/2-1:0] re, input logic [VAL_W/2-1:0] im);
    @(negedge clock);
    bus.chng_row  = IDX_W'(i);
    bus.chng_col  = IDX_W'(j);
    bus.chng_real = re;
    bus.chng_img  = im;
    bus.filt_EN   = 1'b1;
    @(negedge clock);
    bus.filt_EN   = 1'b0;
  endtask

  task automatic finish_record(input int rd0, input int dn0, input int n_rd);
    int t;
    t = 0;
    while (done_cnt < dn0 + 1 && t < 400) begin
      @(negedge clock);
      t++;
    end
    check("done_seen", CHK_W'(done_cnt), CHK_W'(dn0 + 1));
    @(negedge clock);
    check("rd_count", CHK_W'(rd_cnt - rd0), CHK_W'(n_rd));
    check("exp_q_empty", CHK_W'(exp_q.size()), '0);
    check("busy_after", CHK_W'(bus.op_busy), '0);
  endtask

  task automatic run_record(input int i, input int j, input logic [VAL_W/2-1:0] re, input logic [VAL_W/2-1:0] im);
    int n_rd, rd0, dn0;
    n_rd = 0;
    model_pass(i, j, 1'b0, {re, im}, n_rd);
    if (i != j) model_pass(j, i, 1'b1, {re, im}, n_rd);
    rd0 = rd_cnt;
    dn0 = done_cnt;
    start_record(i, j, re, im);
    finish_record(rd0, dn0, n_rd);
  endtask

  task automatic gen_row(input int r, input int i, input int j);
    logic [WORD_W-1:0] word;
    int t, idx;
    for (int w = 0; w < WPR; w++) begin
      for (int k = 0; k < ENTRIES; k++) begin
        t = int'($urandom_range(0, 9));
        if (t == 0)      idx = (1 << IDX_W) - 1;
        else if (t <= 2) idx = i;
        else if (t <= 4) idx = j;
        else             idx = int'($urandom_range(1, 30));
        word[(ENTRIES-1-k)*EW +: EW] = ent(idx, rand_val());
      end
      mem[r * WPR + w] = word;
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [RES_W-1:0] e;
    int n_rd, rd0, dn0, t;
    bus.filt_EN = 1'b0;
    bus.chng_row = '0; bus.chng_col = '0; bus.chng_real = '0; bus.chng_img = '0;
    repeat (3) @(negedge clock);
    check("reset_outs", outs(), '0);
    reset = 1'b1;
    @(negedge clock);
    check("post_reset_outs", outs(), '0);

    // i=3, j=7 two-pass record
    mem[6]  = {ent(3, 48'h0000_0A0A_0001), ent(7, 48'h0000_0B0B_0002), END_E, END_E};
    mem[14] = {ent(3, 48'h0000_0C0C_0003), ent(7, 48'h0000_0D0D_0004), END_E, END_E};
    run_record(3, 7, 24'h000001, 24'h000002);

    // row 5 spans two words, diagonal in word 1 slot 2
    mem[10] = {ent(1, 48'h1), ent(2, 48'h2), ent(8, 48'h8), ent(9, 48'h9)};
    mem[11] = {ent(11, 48'hB), ent(12, 48'h5_0012), ent(5, 48'h5_0055), END_E};
    mem[24] = {ent(5, 48'hC_0005), ent(12, 48'hC_0012), END_E, END_E};
    run_record(5, 12, 24'h123456, 24'h654321);

    // end marker in word 0 slot 1 hides column 9 and a later duplicate
    mem[12] = {ent(6, 48'h6_0006), END_E, ent(9, 48'hBAD9), ent(6, 48'hBAD6)};
    mem[13] = {ent(9, 48'hBAD0), END_E, END_E, END_E};
    mem[18] = {ent(9, 48'h9_0009), ent(2, 48'h2), END_E, END_E};
    run_record(6, 9, 24'h00000A, 24'h00000B);

    // self-admittance with a duplicate diagonal that must not overwrite
    mem[8] = {ent(2, 48'h2), ent(4, 48'h4_0044), ent(4, 48'hDEAD), END_E};
    run_record(4, 4, 24'h0000FF, 24'h0000EE);

    // calc_y stalls 6 cycles in EMIT; a filt_EN pulse meanwhile is ignored
    n_rd = 0;
    model_pass(3, 7, 1'b0, {24'h111111, 24'h222222}, n_rd);
    model_pass(7, 3, 1'b1, {24'h111111, 24'h222222}, n_rd);
    rd0 = rd_cnt; dn0 = done_cnt;
    hold_rdy = 1'b1;
    start_record(3, 7, 24'h111111, 24'h222222);
    t = 0;
    while (!bus.op_EX_EN && t < 100) begin @(negedge clock); t++; end
    check("stall_reached", CHK_W'(bus.op_EX_EN), CHK_W'(1));
    for (int c = 0; c < 6; c++) begin
      e = (exp_q.size() > 0) ? exp_q[0] : '0;
      check("stall_ex_en", CHK_W'(bus.op_EX_EN), CHK_W'(1));
      check("stall_yval1", CHK_W'(bus.op_yVal1), CHK_W'(e[3*VAL_W-1 -: VAL_W]));
      check("stall_yval2", CHK_W'(bus.op_yVal2), CHK_W'(e[2*VAL_W-1 -: VAL_W]));
      check("stall_dval", CHK_W'(bus.op_dVal), CHK_W'(e[VAL_W-1:0]));
      check("stall_flags", CHK_W'({bus.op_pass, bus.op_diag_hit, bus.op_off_hit, bus.op_rd_en, bus.op_busy}),
            CHK_W'({e[RES_W-1 -: 3], 2'b01}));
      bus.filt_EN   = (c == 2);
      bus.chng_row  = 16'd9;
      bus.chng_real = 24'h777777;
      @(negedge clock);
    end
    bus.filt_EN = 1'b0;
    hold_rdy = 1'b0;
    finish_record(rd0, dn0, n_rd);

    // reset while waiting on yMem, then a late dataReady arrives
    force_delay = 6;
    addr_q.push_back(3 * WPR);
    rd0 = rd_cnt;
    start_record(3, 7, 24'h333333, 24'h444444);
    t = 0;
    while (rd_cnt == rd0 && t < 50) begin @(negedge clock); t++; end
    check("rst_rd_seen", CHK_W'(rd_cnt - rd0), CHK_W'(1));
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("rst_mid_outs", outs(), '0);
    @(negedge clock);
    reset = 1'b1;
    repeat (10) @(negedge clock);
    check("rst_late_data_outs", outs(), '0);
    exp_q.delete();
    addr_q.delete();
    force_delay = -1;
    run_record(4, 4, 24'h0000AB, 24'h0000CD);

    // randomized records with random yMem latency and calc_y back-pressure
    rdy_rand = 1'b1;
    for (int r = 0; r < 25; r++) begin
      int i, j;
      i = int'($urandom_range(1, 30));
      j = ($urandom_range(0, 3) == 0) ? i : int'($urandom_range(1, 30));
      gen_row(i, i, j);
      if (j != i) gen_row(j, i, j);
      run_record(i, j, 24'($urandom()), 24'($urandom()));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
